// File: rtl/vending_machine_mp_if.sv
// Handshake/bus bundle for vending_machine_mp: coin, selection, vend and change signals.
// The controller takes the slave modport; the front-end/actuator side takes master.
interface vending_machine_mp_if #(
  parameter int unsigned ID_W      = 2,
  parameter int unsigned CNT_WIDTH = 5
);
  logic                 i_nickle;
  logic                 i_dime;
  logic                 i_quarter;
  logic                 i_sel_valid;
  logic [ID_W-1:0]      i_sel_id;
  logic                 i_cancel;
  logic                 i_vend_ack;
  logic                 i_coin_ack;
  logic [CNT_WIDTH-1:0] o_credit;
  logic                 o_busy;
  logic                 o_vend_valid;
  logic [ID_W-1:0]      o_vend_id;
  logic                 o_coin_valid;
  logic [1:0]           o_coin_type;
  logic                 o_coin_reject;
  logic                 o_sel_err;

  modport master (
    output i_nickle, i_dime, i_quarter, i_sel_valid, i_sel_id, i_cancel,
           i_vend_ack, i_coin_ack,
    input  o_credit, o_busy, o_vend_valid, o_vend_id, o_coin_valid,
           o_coin_type, o_coin_reject, o_sel_err
  );

  modport slave (
    input  i_nickle, i_dime, i_quarter, i_sel_valid, i_sel_id, i_cancel,
           i_vend_ack, i_coin_ack,
    output o_credit, o_busy, o_vend_valid, o_vend_id, o_coin_valid,
           o_coin_type, o_coin_reject, o_sel_err
  );
endinterface

// File: rtl/vending_machine_mp.sv
// Multi-product vending controller: unit-scaled credit, vend handshake, greedy coin change.
// Define VM_TIMEOUT_EN to refund credit automatically after TIMEOUT_CYCLES idle cycles.
module vending_machine_mp #(
  parameter int unsigned           NUM_PROD       = 4,
  parameter logic [8*NUM_PROD-1:0] PRICE_LIST     = 32'h23_19_14_0F,
  parameter int unsigned           MAX_AMOUNT     = 100,
  parameter int unsigned           UNIT           = 5,
  parameter int unsigned           NICKLE         = 5,
  parameter int unsigned           DIME           = 10,
  parameter int unsigned           QUARTER        = 25,
  parameter int unsigned           TIMEOUT_CYCLES = 1000
) (
  input logic i_clk,
  input logic i_rst_n,
  vending_machine_mp_if.slave bus
);

  localparam int unsigned CW = $clog2(MAX_AMOUNT / UNIT + 1);
  localparam int unsigned AW = CW + 1;
  localparam int unsigned IW = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
  localparam logic [AW-1:0] MAX_U = AW'(MAX_AMOUNT / UNIT);
  localparam logic [AW-1:0] N_U   = AW'(NICKLE / UNIT);
  localparam logic [AW-1:0] D_U   = AW'(DIME / UNIT);
  localparam logic [AW-1:0] Q_U   = AW'(QUARTER / UNIT);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [IW-1:0]   vend_id_q, vend_id_d;
  logic            coin_valid_q, coin_valid_d;
  logic [1:0]      coin_type_q, coin_type_d;
  logic            coin_reject_q, coin_reject_d;
  logic            sel_err_q, sel_err_d;

  logic [AW-1:0]   coin_u, credit_raw, price_u, diff, coin_left;
  logic            multi, any_coin, accept, in_ready, sel_ok, do_cancel;
  logic            tmo_fire;

  function automatic logic [1:0] pick(input logic [AW-1:0] v);
    if (v >= Q_U) return 2'b11;
    if (v >= D_U) return 2'b10;
    return 2'b01;
  endfunction

  function automatic logic [AW-1:0] coin_value(input logic [1:0] t);
    case (t)
      2'b11:   return Q_U;
      2'b10:   return D_U;
      default: return N_U;
    endcase
  endfunction

  // Credit after this cycle's coin; select/cancel decisions are made on this value.
  always_comb begin
    any_coin   = bus.i_nickle | bus.i_dime | bus.i_quarter;
    multi      = !$onehot0({bus.i_nickle, bus.i_dime, bus.i_quarter});
    coin_u     = bus.i_quarter ? Q_U : bus.i_dime ? D_U : bus.i_nickle ? N_U : '0;
    in_ready   = (state_q == S_IDLE) || (state_q == S_CREDIT);
    accept     = in_ready && any_coin && !multi && (({1'b0, credit_q} + coin_u) <= MAX_U);
    credit_raw = {1'b0, credit_q} + (accept ? coin_u : '0);
    price_u    = '0;
    for (int unsigned i = 0; i < NUM_PROD; i++) begin
      if (32'(bus.i_sel_id) == i) price_u = AW'(PRICE_LIST[8*i +: 8] / 8'(UNIT));
    end
    sel_ok     = 32'(bus.i_sel_id) < NUM_PROD;
    diff       = credit_raw - price_u;
    coin_left  = {1'b0, credit_q} - coin_value(coin_type_q);
    do_cancel  = bus.i_cancel || tmo_fire;
  end

`ifdef VM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_fire = (state_q == S_CREDIT) && (tmo_q == TW'(TIMEOUT_CYCLES - 1)) &&
                    !accept && !bus.i_sel_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                                   tmo_q <= '0;
    else if (state_q != S_CREDIT || accept || bus.i_sel_valid || tmo_fire) tmo_q <= '0;
    else                                                            tmo_q <= tmo_q + 1'b1;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_id_d     = vend_id_q;
    coin_valid_d  = coin_valid_q;
    coin_type_d   = coin_type_q;
    coin_reject_d = any_coin && !accept;
    sel_err_d     = 1'b0;
    unique case (state_q)
      S_IDLE, S_CREDIT: begin
        credit_d = credit_raw[CW-1:0];
        state_d  = (credit_raw != '0) ? S_CREDIT : S_IDLE;
        if (do_cancel) begin
          if (credit_raw != '0) begin
            state_d      = S_CHANGE;
            coin_valid_d = 1'b1;
            coin_type_d  = pick(credit_raw);
          end
        end else if (bus.i_sel_valid) begin
          if (!sel_ok || diff[AW-1]) begin
            sel_err_d = 1'b1;
          end else begin
            vend_id_d = bus.i_sel_id;
            credit_d  = diff[CW-1:0];
            state_d   = S_VEND;
          end
        end
      end
      S_VEND: begin
        if (bus.i_vend_ack) begin
          if (credit_q != '0) begin
            state_d      = S_CHANGE;
            coin_valid_d = 1'b1;
            coin_type_d  = pick({1'b0, credit_q});
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_CHANGE: begin
        // Drop valid for one cycle after each ack, then present the next greedy coin.
        if (coin_valid_q) begin
          if (bus.i_coin_ack) begin
            coin_valid_d = 1'b0;
            credit_d     = coin_left[CW-1:0];
            if (coin_left == '0) state_d = S_IDLE;
          end
        end else begin
          coin_valid_d = 1'b1;
          coin_type_d  = pick({1'b0, credit_q});
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      vend_id_q     <= '0;
      coin_valid_q  <= 1'b0;
      coin_type_q   <= '0;
      coin_reject_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_id_q     <= vend_id_d;
      coin_valid_q  <= coin_valid_d;
      coin_type_q   <= coin_type_d;
      coin_reject_q <= coin_reject_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign bus.o_credit      = credit_q;
  assign bus.o_busy        = (state_q == S_VEND) || (state_q == S_CHANGE);
  assign bus.o_vend_valid  = (state_q == S_VEND);
  assign bus.o_vend_id     = vend_id_q;
  assign bus.o_coin_valid  = coin_valid_q;
  assign bus.o_coin_type   = coin_type_q;
  assign bus.o_coin_reject = coin_reject_q;
  assign bus.o_sel_err     = sel_err_q;

endmodule
